// File: rtl/imem_loader.sv
// Instruction-memory loader: parses SYNC/count/data/checksum frames from a byte
// stream, writes little-endian 32-bit words and gates the processor reset.
module imem_loader #(
    parameter int          ADDR_WIDTH     = 8,
    parameter int          MAX_WORDS      = 255,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [31:0]           wr_data,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            err_code
);

    localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    state_t                  state_q;
    logic                    rx_ready_q;
    logic                    wr_en_q;
    logic [ADDR_WIDTH-1:0]   wr_addr_q;
    logic [31:0]             wr_data_q;
    logic                    cpu_reset_q;
    logic                    done_q;
    logic                    error_q;
    logic [1:0]              err_code_q;
    logic [1:0]              byte_cnt_q;
    logic [7:0]              word_idx_q;
    logic [7:0]              count_q;
    logic [7:0]              csum_q;
    logic [23:0]             asm_q;
    logic [TW-1:0]           tmo_q;

    logic        accept;
    logic        in_frame;
    logic [31:0] word_d;

    assign accept   = rx_valid && rx_ready_q;
    assign in_frame = (state_q == S_COUNT) || (state_q == S_DATA) || (state_q == S_CHECK);
    // Earlier bytes of the word sit in asm_q; the incoming byte is the top byte.
    assign word_d   = {rx_data, asm_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rx_ready_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= 2'b00;
            byte_cnt_q  <= '0;
            word_idx_q  <= '0;
            count_q     <= '0;
            csum_q      <= '0;
            asm_q       <= '0;
            tmo_q       <= '0;
        end else begin
            rx_ready_q <= 1'b1;
            wr_en_q    <= 1'b0;

            if (in_frame && !accept) begin
                tmo_q <= tmo_q + 1'b1;
            end else begin
                tmo_q <= '0;
            end

            if (in_frame && !accept && tmo_q == TMO_LAST) begin
                state_q     <= S_ERR;
                error_q     <= 1'b1;
                err_code_q  <= 2'b11;
                cpu_reset_q <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE, S_DONE, S_ERR: begin
                        if (accept && rx_data == SYNC_BYTE) begin
                            state_q     <= S_COUNT;
                            cpu_reset_q <= 1'b1;
                            done_q      <= 1'b0;
                            error_q     <= 1'b0;
                            err_code_q  <= 2'b00;
                        end
                    end
                    S_COUNT: begin
                        if (accept) begin
                            count_q    <= rx_data;
                            csum_q     <= '0;
                            word_idx_q <= '0;
                            byte_cnt_q <= '0;
                            if (int'(rx_data) > MAX_WORDS) begin
                                state_q    <= S_ERR;
                                error_q    <= 1'b1;
                                err_code_q <= 2'b10;
                            end else if (rx_data == 8'd0) begin
                                state_q <= S_CHECK;
                            end else begin
                                state_q <= S_DATA;
                            end
                        end
                    end
                    S_DATA: begin
                        if (accept) begin
                            asm_q      <= {rx_data, asm_q[23:8]};
                            csum_q     <= csum_q ^ rx_data;
                            byte_cnt_q <= byte_cnt_q + 2'd1;
                            if (byte_cnt_q == 2'd3) begin
                                wr_en_q    <= 1'b1;
                                wr_addr_q  <= ADDR_WIDTH'(word_idx_q);
                                wr_data_q  <= word_d;
                                word_idx_q <= word_idx_q + 8'd1;
                                if (word_idx_q == count_q - 8'd1) begin
                                    state_q <= S_CHECK;
                                end
                            end
                        end
                    end
                    S_CHECK: begin
                        if (accept) begin
                            if (rx_data == csum_q) begin
                                state_q     <= S_DONE;
                                done_q      <= 1'b1;
                                cpu_reset_q <= 1'b0;
                            end else begin
                                state_q    <= S_ERR;
                                error_q    <= 1'b1;
                                err_code_q <= 2'b01;
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign rx_ready  = rx_ready_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign cpu_reset = cpu_reset_q;
    assign done      = done_q;
    assign error     = error_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed frame table, multi-cycle corner sequences,
// and random frames checked against a byte-stream parsing model.
module tb_imem_loader;

    localparam int MAXW = 4;
    localparam int TMO  = 1000;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        cpu_reset;
    logic        done;
    logic        error;
    logic [1:0]  err_code;

    always #5 clk = ~clk;

    imem_loader #(
        .ADDR_WIDTH(8),
        .MAX_WORDS(MAXW),
        .SYNC_BYTE(8'hA5),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .cpu_reset(cpu_reset),
        .done(done),
        .error(error),
        .err_code(err_code)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [39:0] wq[$];      // observed writes {addr, data}
    logic [39:0] exp_w[$];   // model writes
    logic [7:0]  s[$];       // stream under test
    logic        m_d, m_e;
    logic [1:0]  m_ec;

    always @(negedge clk) begin
        if (wr_en) wq.push_back({wr_addr, wr_data});
    end

    typedef struct {
        logic [95:0] stream;
        int          len;
        int          nw;
        logic [31:0] w0;
        logic [31:0] w1;
        logic        d;
        logic        e;
        logic [1:0]  ec;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        idle(gap);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
    endtask

    // Sends s[], then stops at the negedge right after the last byte was accepted.
    task automatic send_stream(input int maxgap);
        for (int k = 0; k < s.size(); k++) send(s[k], $urandom_range(0, maxgap));
        idle(1);
    endtask

    task automatic check_status(input string tag, input logic d, input logic e, input logic [1:0] ec);
        check({tag, " done"}, 40'(done), 40'(d));
        check({tag, " error"}, 40'(error), 40'(e));
        check({tag, " err_code"}, 40'(err_code), 40'(ec));
        check({tag, " cpu_reset"}, 40'(cpu_reset), 40'(!d));
    endtask

    // Frame parser from the format rules: skip to SYNC, read N, walk 4N data bytes, compare checksum.
    task automatic model();
        int          i;
        int          n;
        logic [7:0]  x;
        logic [31:0] word;
        i = 0;
        exp_w.delete();
        while (i < s.size()) begin
            if (s[i] != 8'hA5) begin
                i++;
                continue;
            end
            n = int'(s[i+1]);
            if (n > MAXW) begin
                m_d = 1'b0; m_e = 1'b1; m_ec = 2'b10;
                i += 2;
                continue;
            end
            x = 8'h00;
            for (int w = 0; w < n; w++) begin
                word = {s[i+5+4*w], s[i+4+4*w], s[i+3+4*w], s[i+2+4*w]};
                x ^= word[7:0] ^ word[15:8] ^ word[23:16] ^ word[31:24];
                exp_w.push_back({8'(w), word});
            end
            if (s[i+2+4*n] == x) begin
                m_d = 1'b1; m_e = 1'b0; m_ec = 2'b00;
            end else begin
                m_d = 1'b0; m_e = 1'b1; m_ec = 2'b01;
            end
            i += 3 + 4*n;
        end
    endtask

    task automatic load_vec(input int t);
        s.delete();
        for (int k = 0; k < tbl[t].len; k++) s.push_back(tbl[t].stream[95-8*k -: 8]);
    endtask

    initial begin
        tbl[0] = '{96'hA5_02_13_05_A0_00_B3_85_A5_00_25_00, 11, 2, 32'h00A00513, 32'h00A585B3, 1'b1, 1'b0, 2'b00};
        tbl[1] = '{96'hA5_02_13_05_A0_00_B3_85_A5_00_24_00, 11, 2, 32'h00A00513, 32'h00A585B3, 1'b0, 1'b1, 2'b01};
        tbl[2] = '{96'h00_FF_A5_00_00_00_00_00_00_00_00_00,  5, 0, 32'h0,        32'h0,        1'b1, 1'b0, 2'b00};
        tbl[3] = '{96'hA5_05_11_22_33_44_00_00_00_00_00_00,  6, 0, 32'h0,        32'h0,        1'b0, 1'b1, 2'b10};
        tbl[4] = '{96'hA5_00_01_00_00_00_00_00_00_00_00_00,  3, 0, 32'h0,        32'h0,        1'b0, 1'b1, 2'b01};
        tbl[5] = '{96'hA5_01_13_05_A0_00_B6_00_00_00_00_00,  7, 1, 32'h00A00513, 32'h0,        1'b1, 1'b0, 2'b00};

        // Reset with a SYNC byte offered: it must be ignored.
        reset    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        repeat (3) @(negedge clk);
        check("rst rx_ready", 40'(rx_ready), 40'd0);
        check("rst wr_en", 40'(wr_en), 40'd0);
        check("rst wr_addr", 40'(wr_addr), 40'd0);
        check("rst wr_data", 40'(wr_data), 40'd0);
        check("rst cpu_reset", 40'(cpu_reset), 40'd1);
        check("rst done", 40'(done), 40'd0);
        check("rst error", 40'(error), 40'd0);
        check("rst err_code", 40'(err_code), 40'd0);
        reset    = 1'b0;
        rx_valid = 1'b0;
        idle(2);
        check("post-rst rx_ready", 40'(rx_ready), 40'd1);
        check("post-rst cpu_reset", 40'(cpu_reset), 40'd1);
        $display("reset: outputs at reset values");

        for (int t = 0; t < 6; t++) begin
            load_vec(t);
            wq.delete();
            send_stream(0);
            check_status($sformatf("vec%0d", t), tbl[t].d, tbl[t].e, tbl[t].ec);
            idle(2);
            check($sformatf("vec%0d nwrites", t), 40'(wq.size()), 40'(tbl[t].nw));
            if (tbl[t].nw > 0 && wq.size() > 0) check($sformatf("vec%0d w0", t), wq[0], {8'd0, tbl[t].w0});
            if (tbl[t].nw > 1 && wq.size() > 1) check($sformatf("vec%0d w1", t), wq[1], {8'd1, tbl[t].w1});
            $display("vec%0d: %0d bytes, %0d writes, done=%0b error=%0b err_code=%0d",
                     t, tbl[t].len, wq.size(), done, error, err_code);
        end

        // Timeout: stall inside a word, then recover with a good frame.
        s.delete();
        s.push_back(8'hA5); s.push_back(8'h01); s.push_back(8'h13);
        wq.delete();
        send_stream(0);
        idle(TMO - 10);
        check("tmo early error", 40'(error), 40'd0);
        idle(15);
        check_status("tmo", 1'b0, 1'b1, 2'b11);
        load_vec(5);
        send_stream(0);
        check_status("tmo recover", 1'b1, 1'b0, 2'b00);
        idle(2);
        check("tmo recover nwrites", 40'(wq.size()), 40'd1);
        if (wq.size() > 0) check("tmo recover w0", wq[0], {8'd0, 32'h00A00513});
        $display("timeout: err_code=%0d after stall, recovered done=%0b", 2'b11, done);

        // Reset asserted one cycle after byte 05 of the 2-word frame.
        s.delete();
        s.push_back(8'hA5); s.push_back(8'h02); s.push_back(8'h13); s.push_back(8'h05);
        send_stream(0);
        reset = 1'b1;
        @(negedge clk);
        check("midrst rx_ready", 40'(rx_ready), 40'd0);
        check("midrst cpu_reset", 40'(cpu_reset), 40'd1);
        check("midrst done", 40'(done), 40'd0);
        check("midrst error", 40'(error), 40'd0);
        check("midrst wr_en", 40'(wr_en), 40'd0);
        reset = 1'b0;
        idle(2);
        wq.delete();
        load_vec(0);
        send_stream(0);
        check_status("midrst reload", 1'b1, 1'b0, 2'b00);
        idle(2);
        check("midrst reload nwrites", 40'(wq.size()), 40'd2);
        if (wq.size() > 1) check("midrst reload w1", wq[1], {8'd1, 32'h00A585B3});
        $display("mid-frame reset: reload done=%0b writes=%0d", done, wq.size());

        // Random frames with noise, gaps, bad checksums and overflow counts.
        for (int f = 0; f < 30; f++) begin
            int          n;
            logic [7:0]  x;
            logic [7:0]  b;
            s.delete();
            repeat ($urandom_range(0, 2)) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h5A;
                s.push_back(b);
            end
            n = $urandom_range(0, MAXW + 1);
            s.push_back(8'hA5);
            s.push_back(8'(n));
            if (n <= MAXW) begin
                x = 8'h00;
                for (int k = 0; k < 4*n; k++) begin
                    b = 8'($urandom);
                    x ^= b;
                    s.push_back(b);
                end
                if ($urandom_range(0, 3) == 0) x ^= 8'(1 << $urandom_range(0, 7));
                s.push_back(x);
            end
            model();
            wq.delete();
            send_stream(2);
            check_status($sformatf("rand%0d", f), m_d, m_e, m_ec);
            idle(2);
            check($sformatf("rand%0d nwrites", f), 40'(wq.size()), 40'(exp_w.size()));
            for (int k = 0; k < exp_w.size() && k < wq.size(); k++)
                check($sformatf("rand%0d write%0d", f, k), wq[k], exp_w[k]);
            $display("rand%0d: N=%0d bytes=%0d writes=%0d done=%0b error=%0b err_code=%0d",
                     f, n, s.size(), wq.size(), done, error, err_code);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
